// File: rtl/reg_file_16x16.sv
// reg_file_16x16: 16x16 register file, registered dual read with write bypass
// and a post-reset sweep that zeroes every register while Busy is high.
module reg_file_16x16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] W_data,
  input  logic [ADDR_W-1:0] W_addr,
  input  logic              W_wr,
  input  logic [ADDR_W-1:0] Rp_addr,
  input  logic              Rp_rd,
  input  logic [ADDR_W-1:0] Rq_addr,
  input  logic              Rq_rd,
  output logic [DATA_W-1:0] Rp_data,
  output logic [DATA_W-1:0] Rq_data,
  output logic              Busy
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rp_q, rp_d, rq_q, rq_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              clr;
  assign clr = state_q == CLEAR;
  always_comb begin
    state_d = (clr && cnt_q == ADDR_W'(DEPTH-1)) ? READY : state_q;
    cnt_d   = clr ? cnt_q + 1'b1 : cnt_q;
    rp_d    = clr ? '0 : !Rp_rd ? rp_q : (W_wr && W_addr == Rp_addr) ? W_data : mem_q[Rp_addr];
    rq_d    = clr ? '0 : !Rq_rd ? rq_q : (W_wr && W_addr == Rq_addr) ? W_data : mem_q[Rq_addr];
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rp_q    <= '0;
      rq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rp_q    <= rp_d;
      rq_q    <= rq_d;
    end
  end
  // Storage has no reset; the sweep clears it one word per edge instead.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (clr) mem_q[cnt_q] <= '0;
      else if (W_wr) mem_q[W_addr] <= W_data;
    end
  end
  assign Rp_data = rp_q;
  assign Rq_data = rq_q;
  assign Busy    = clr;
endmodule

// File: tb/tb_reg_file_16x16.sv
// tb_reg_file_16x16: vector table, hand sequences and random traffic vs an array model.
module tb_reg_file_16x16;
  logic        Clk = 0, Reset = 0, W_wr = 0, Rp_rd = 0, Rq_rd = 0;
  logic [15:0] W_data = 0;
  logic [3:0]  W_addr = 0, Rp_addr = 0, Rq_addr = 0;
  logic [15:0] Rp_data, Rq_data;
  logic        Busy;
  int n_cmp = 0, n_err = 0;
  logic [15:0] mem_m [16];
  logic [15:0] p_m, q_m;

  typedef struct {
    logic wr; logic [3:0] wa; logic [15:0] wd;
    logic prd; logic [3:0] pa; logic qrd; logic [3:0] qa;
    logic [15:0] ep, eq;
  } vec_t;
  vec_t tbl [10];

  reg_file_16x16 dut (
    .Clk(Clk), .Reset(Reset), .W_data(W_data), .W_addr(W_addr), .W_wr(W_wr),
    .Rp_addr(Rp_addr), .Rp_rd(Rp_rd), .Rq_addr(Rq_addr), .Rq_rd(Rq_rd),
    .Rp_data(Rp_data), .Rq_data(Rq_data), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mem_m[i] = 16'h0;
    p_m = 16'h0;
    q_m = 16'h0;
  endtask

  // A read issued alongside a write to the same register sees the new value.
  task automatic apply(input logic wr, input logic [3:0] wa, input logic [15:0] wd,
                       input logic prd, input logic [3:0] pa, input logic qrd, input logic [3:0] qa);
    W_wr = wr; W_addr = wa; W_data = wd;
    Rp_rd = prd; Rp_addr = pa; Rq_rd = qrd; Rq_addr = qa;
    cyc();
    if (wr) mem_m[wa] = wd;
    if (prd) p_m = mem_m[pa];
    if (qrd) q_m = mem_m[qa];
  endtask

  task automatic sweep(input string tag);
    int n = 0;
    while (Busy === 1'b1 && n < 40) begin
      chk({tag, "_p_zero"}, Rp_data, 16'h0);
      chk({tag, "_q_zero"}, Rq_data, 16'h0);
      cyc();
      n++;
    end
    chk({tag, "_busy_edges"}, 16'(n), 16'd16);
    chk({tag, "_busy_low"}, {15'h0, Busy}, 16'h0);
    W_wr = 0; Rp_rd = 0; Rq_rd = 0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      apply(0, 0, 0, 1, 4'(a), 1, 4'(15 - a));
      chk({tag, "_p"}, Rp_data, p_m);
      chk({tag, "_q"}, Rq_data, q_m);
      chk({tag, "_p_zero"}, Rp_data, 16'h0);
    end
  endtask

  initial begin
    tbl[0] = '{1, 5, 16'hAAAA, 0, 0, 0, 0, 16'h0000, 16'h0000};
    tbl[1] = '{0, 0, 16'h0000, 1, 5, 0, 0, 16'hAAAA, 16'h0000};
    tbl[2] = '{1, 5, 16'h5555, 0, 5, 0, 0, 16'hAAAA, 16'h0000};
    tbl[3] = '{1, 7, 16'h1234, 1, 7, 1, 7, 16'h1234, 16'h1234};
    tbl[4] = '{1, 1, 16'hFFFF, 0, 0, 0, 0, 16'h1234, 16'h1234};
    tbl[5] = '{1, 2, 16'h5555, 0, 0, 0, 0, 16'h1234, 16'h1234};
    tbl[6] = '{0, 0, 16'h0000, 1, 1, 1, 2, 16'hFFFF, 16'h5555};
    tbl[7] = '{0, 0, 16'h0000, 1, 3, 1, 3, 16'h0000, 16'h0000};
    tbl[8] = '{1, 0, 16'hBEEF, 1, 0, 1, 5, 16'hBEEF, 16'h5555};
    tbl[9] = '{0, 9, 16'h0000, 1, 5, 1, 0, 16'h5555, 16'hBEEF};

    // Reset, with a write to R3 and reads held active during the whole sweep.
    Reset = 1; W_wr = 1; W_addr = 3; W_data = 16'hFFFF; Rp_rd = 1; Rq_rd = 1;
    cyc();
    Reset = 0;
    chk("rst_busy", {15'h0, Busy}, 16'h1);
    model_clear();
    sweep("sweep1");
    read_all("clr1");

    foreach (tbl[i]) begin
      apply(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].prd, tbl[i].pa, tbl[i].qrd, tbl[i].qa);
      chk($sformatf("vec%0d_p", i), Rp_data, tbl[i].ep);
      chk($sformatf("vec%0d_q", i), Rq_data, tbl[i].eq);
    end

    for (int k = 0; k < 300; k++) begin
      apply($urandom_range(0, 1), 4'($urandom), 16'($urandom), $urandom_range(0, 1),
            4'($urandom), $urandom_range(0, 1), 4'($urandom));
      chk("rand_p", Rp_data, p_m);
      chk("rand_q", Rq_data, q_m);
      chk("rand_busy", {15'h0, Busy}, 16'h0);
    end

    // Mid-sweep reset: outputs nonzero beforehand, then sweep restarts from scratch.
    apply(1, 9, 16'hC0DE, 1, 9, 1, 9);
    chk("pre_rst_p", Rp_data, 16'hC0DE);
    W_wr = 0; Rp_rd = 0; Rq_rd = 0;
    Reset = 1;
    cyc();
    Reset = 0;
    chk("rst2_p_zero", Rp_data, 16'h0);
    chk("rst2_q_zero", Rq_data, 16'h0);
    for (int i = 0; i < 8; i++) cyc();
    chk("mid_busy", {15'h0, Busy}, 16'h1);
    Reset = 1;
    cyc();
    Reset = 0;
    chk("rst3_busy", {15'h0, Busy}, 16'h1);
    chk("rst3_p_zero", Rp_data, 16'h0);
    model_clear();
    sweep("sweep2");
    read_all("clr2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
